event_sampler: RTL and testbench
================================

# event_sampler

Multi-channel trigger-driven data sampler for the process-synchronisation area. On each trigger pulse it captures NUM_CH data lanes. Per lane, it samples either at the trigger edge (pre-update view) or one clock later (post-update view, the registered equivalent of sampling after the non-blocking region). The capture is timestamped and queued in a small FIFO behind a valid/ready output. It replaces ad-hoc event-based sampling in benches with a deterministic, cycle-accurate RTL block.

## Interface
- NUM_CH, 4, number of data lanes (1..16)
- DATA_W, 8, width of each lane
- DEPTH, 4, record FIFO depth (power of two, ≥2)
- TS_W, 16, timestamp width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- trig  in  1  capture request, sampled each rising edge
- mode  in  NUM_CH  per-lane sample point: 0 = immediate, 1 = deferred; sampled with trig
- din  in  NUM_CH*DATA_W  lane data, lane i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  FIFO head holds a record
- out_ready  in  1  consumer accepts head
- out_data  out  NUM_CH*DATA_W  head record lane values
- out_mode  out  NUM_CH  mode vector the head record was captured with
- out_ts  out  TS_W  timestamp of the trigger edge
- overflow  out  1  sticky: a record was dropped
- drop_cnt  out  8  dropped-record count, saturates at 255
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt

## Operation
- Free-running counter ts_cnt: increments every edge and wraps from 2^TS_W−1 to 0.
- Capture stage (edge k, trig=1): latch lane values din, mode vector, and ts_cnt value at edge k into a pending register, and set pend=1.
- Commit stage (edge k+1, pend=1): build the record.
  - Lane i with latched mode=0 takes the value latched at edge k.
  - Lane i with latched mode=1 takes din as sampled at edge k+1.
  - Push the record into the FIFO. pend clears unless a new trigger arrives at edge k+1.
- Back-to-back triggers are supported at full rate, one record per trigger. A trigger at k+1 latches a new pending record while the previous one commits.
- FIFO: DEPTH entries. Push is accepted if not full, or if full with a pop in the same cycle (out_valid & out_ready). Pop occurs on out_valid & out_ready.
- Overflow: if a commit finds the FIFO full and no pop that cycle, the record is discarded, overflow sets to 1, and drop_cnt increments (saturating at 255).
- clr_ovf=1 zeroes overflow and drop_cnt at that edge. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- The output fields (out_data, out_mode, out_ts) hold the FIFO head. They are stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, overflow=0, drop_cnt=0, ts_cnt=0, pend=0, FIFO empty. out_data, out_mode and out_ts are 0.
- Reset asserted mid-operation discards any pending record and all FIFO contents immediately (asynchronous). A trigger coinciding with reset deassertion is captured only if rst is low at that edge.

## Timing
- Trigger-to-out_valid latency is 2 edges when the FIFO is empty: capture at k, commit at k+1, out_valid=1 after k+1.
- Immediate lanes see din as sampled at edge k. Deferred lanes see din as sampled at edge k+1, so a value first driven at k+1 is visible only to deferred lanes.
- Throughput is one record per clock in and one per clock out. Full and empty both have no bubble with simultaneous push and pop.
- Push and pop on an empty FIFO: out_valid rises the edge after the push; there is no same-cycle bypass.
- mode is only meaningful on trigger cycles; it is ignored otherwise.

## Test plan
- Basic: NUM_CH=4. din lane0=0x11 at edge 5 with trig=1 and mode=4'b0000, then lane0=0x22 at edge 6 → record lane0=0x11, out_ts=5, out_valid=1 after edge 6.
- Deferred: same stimulus with mode=4'b0001 → lane0=0x22 and other lanes take their edge-5 values; out_mode=4'b0001.
- Back-to-back: trig high for 4 consecutive edges, out_ready=1 → 4 records with out_ts of n, n+1, n+2, n+3, and no drops.
- Overflow: DEPTH=4, out_ready=0, 6 triggers → 4 records queued, overflow=1, drop_cnt=2. Assert clr_ovf → both return to 0, and the 4 records drain intact.
- Full with simultaneous pop: FIFO full, trigger commit in the same cycle as out_ready=1 → push accepted, drop_cnt unchanged, occupancy stays 4.
- Reset mid-operation: assert rst asynchronously with pend=1 and 3 entries queued → out_valid=0 immediately, no stale record after release. ts_cnt restarts from 0, and the first post-reset trigger at edge 2 yields out_ts=2.

Source files
------------

// File: rtl/event_sampler.sv
// Trigger-driven multi-lane sampler: captures lanes on trig, resolves per-lane
// immediate/deferred sample points one clock later, and queues timestamped records.
module event_sampler #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trig,
  input  logic [NUM_CH-1:0]        mode,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_mode,
  output logic [TS_W-1:0]          out_ts,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int LW = NUM_CH * DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              pend_q, pend_d;
  logic [LW-1:0]     pdata_q;
  logic [NUM_CH-1:0] pmode_q;
  logic [TS_W-1:0]   pts_q;

  logic [LW-1:0]     data_mem_q [DEPTH];
  logic [NUM_CH-1:0] mode_mem_q [DEPTH];
  logic [TS_W-1:0]   ts_mem_q   [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;

  logic              full, empty, pop, push, drop;
  logic [LW-1:0]     rec_data;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign pop   = !empty && out_ready;
  assign push  = pend_q && (!full || pop);
  assign drop  = pend_q && full && !pop;

  // Deferred lanes take the live bus at commit time; immediate lanes keep the trigger-edge copy.
  always_comb begin
    rec_data = pdata_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pmode_q[i]) rec_data[i*DATA_W +: DATA_W] = din[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ts_d     = ts_q + 1'b1;
    pend_d   = trig;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 8'd1 : sat_inc(drop_q);
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      ts_q     <= ts_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage carries no reset; pend_q and cnt_q decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (trig) begin
      pdata_q <= din;
      pmode_q <= mode;
      pts_q   <= ts_q;
    end
    if (push) begin
      data_mem_q[wr_ptr_q] <= rec_data;
      mode_mem_q[wr_ptr_q] <= pmode_q;
      ts_mem_q[wr_ptr_q]   <= pts_q;
    end
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_mode  = out_valid ? mode_mem_q[rd_ptr_q] : '0;
  assign out_ts    = out_valid ? ts_mem_q[rd_ptr_q]   : '0;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_event_sampler.sv
// Self-checking bench for event_sampler: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_event_sampler;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TW = 16;
  localparam int LW = NC * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic [NC-1:0] mode = '0;
  logic [LW-1:0] din = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_data;
  logic [NC-1:0] out_mode;
  logic [TW-1:0] out_ts;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  event_sampler #(.NUM_CH(NC), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW)) dut (
    .clk(clk), .rst(rst), .trig(trig), .mode(mode), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .out_ts(out_ts), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: pending capture, then a record queue with drop accounting.
  typedef struct packed {
    logic [LW-1:0] d;
    logic [NC-1:0] m;
    logic [TW-1:0] ts;
  } rec_t;

  rec_t          mq[$];
  bit            m_pend;
  logic [LW-1:0] m_pd;
  logic [NC-1:0] m_pm;
  logic [TW-1:0] m_pts;
  logic [TW-1:0] m_ts;
  bit            m_ovf;
  int            m_drop;
  bit            m_pop, m_dropnow;
  rec_t          m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pend = 0;
      m_ts   = '0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      m_pop = (mq.size() > 0) && out_ready;
      m_dropnow = 0;
      if (m_pend) begin
        m_r.ts = m_pts;
        m_r.m  = m_pm;
        for (int i = 0; i < NC; i++)
          m_r.d[i*DW +: DW] = m_pm[i] ? din[i*DW +: DW] : m_pd[i*DW +: DW];
        if (mq.size() == DEPTH && !m_pop) m_dropnow = 1;
      end
      if (m_dropnow) begin
        m_ovf  = 1;
        m_drop = clr_ovf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr_ovf) begin
        m_ovf  = 0;
        m_drop = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_pend && !m_dropnow) mq.push_back(m_r);
      m_pend = trig;
      if (trig) begin
        m_pd  = din;
        m_pm  = mode;
        m_pts = m_ts;
      end
      m_ts = m_ts + 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_din();
    for (int i = 0; i < NC; i++) din[i*DW +: DW] = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; mode = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 1'b1; mode = '1; din = 32'hDEADBEEF;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_mode !== '0) begin errors++; $display("FAIL reset_mode got %h exp 0", out_mode); end
    checks++; if (out_ts !== '0) begin errors++; $display("FAIL reset_ts got %h exp 0", out_ts); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    trig = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_capture(input bit deferred);
    logic [LW-1:0] first;
    do_reset();
    repeat (5) cyc();
    din = 32'hA3B2C111;
    first = din;
    trig = 1'b1; mode = deferred ? 4'b0001 : 4'b0000;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_early_valid got %b exp 0", out_valid); end
    trig = 1'b0; mode = 4'b1111;
    din = 32'h5E6F7022;
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cap_valid got %b exp 1", out_valid); end
    checks++; if (out_ts !== 16'd5) begin errors++; $display("FAIL cap_ts got %0d exp 5", out_ts); end
    checks++;
    if (out_data !== (deferred ? {first[31:8], 8'h22} : first)) begin
      errors++; $display("FAIL cap_data got %h exp %h", out_data, deferred ? {first[31:8], 8'h22} : first);
    end
    checks++;
    if (out_mode !== (deferred ? 4'b0001 : 4'b0000)) begin
      errors++; $display("FAIL cap_mode got %b exp %b", out_mode, deferred ? 4'b0001 : 4'b0000);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_pop got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] n;
    int got;
    do_reset();
    repeat (3) cyc();
    out_ready = 1'b1;
    n = m_ts;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      trig = (k < 4); mode = 4'($urandom_range(0, 15)); rand_din();
      cyc();
      if (out_valid) begin
        checks++;
        if (out_ts !== n + TW'(got)) begin errors++; $display("FAIL b2b_ts got %0d exp %0d", out_ts, n + TW'(got)); end
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int got;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      trig = 1'b1; mode = 4'($urandom_range(0, 15)); rand_din();
      cyc();
    end
    trig = 1'b0; rand_din();
    cyc(); cyc();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_flag got %b exp 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clr_drop got %0d exp 0", drop_cnt); end
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        checks++;
        if (out_ts !== TW'(got)) begin errors++; $display("FAIL ovf_drain_ts got %0d exp %0d", out_ts, got); end
        checks++;
        if (mq.size() == 0 || out_data !== mq[0].d || out_mode !== mq[0].m) begin
          errors++; $display("FAIL ovf_drain_rec got %h/%b", out_data, out_mode);
        end
        got++;
      end
      cyc();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL ovf_drain_count got %0d exp 4", got); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    int got;
    logic [TW-1:0] last_ts;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      trig = 1'b1; rand_din();
      cyc();
    end
    trig = 1'b0;
    cyc();
    last_ts = m_ts;
    trig = 1'b1; rand_din();
    cyc();
    trig = 1'b0; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL fullpop_drop got %0d exp 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", overflow); end
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        got++;
        if (got == 4) begin
          checks++;
          if (out_ts !== last_ts) begin errors++; $display("FAIL fullpop_last_ts got %0d exp %0d", out_ts, last_ts); end
        end
      end
      cyc();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL fullpop_count got %0d exp 4", got); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    trig = 1'b1;
    for (int k = 0; k < 272; k++) begin rand_din(); cyc(); end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d exp 255", drop_cnt); end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_vs_drop_cnt got %0d exp 1", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop_ovf got %b exp 1", overflow); end
    trig = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      trig = 1'b1; rand_din();
      cyc();
    end
    trig = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b exp 0", out_valid); end
    trig = 1'b1; mode = 4'b1010; rand_din();
    cyc();
    trig = 1'b0; rand_din();
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid got %b exp 1", out_valid); end
    checks++; if (out_ts !== 16'd2) begin errors++; $display("FAIL mid_post_ts got %0d exp 2", out_ts); end
    checks++;
    if (mq.size() == 0 || out_data !== mq[0].d) begin
      errors++; $display("FAIL mid_post_data got %h", out_data);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) ready_pct = $urandom_range(10, 95);
      trig      = ($urandom_range(0, 99) < 60);
      mode      = 4'($urandom_range(0, 15));
      rand_din();
      out_ready = ($urandom_range(0, 99) < ready_pct);
      clr_ovf   = ($urandom_range(0, 99) < 2);
      cyc();
      checks++;
      if (out_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", k, out_valid, mq.size() > 0);
      end else if (out_valid) begin
        checks++;
        if (out_data !== mq[0].d || out_mode !== mq[0].m || out_ts !== mq[0].ts) begin
          errors++;
          $display("FAIL rnd_rec cyc %0d got %h/%b/%0d exp %h/%b/%0d", k, out_data, out_mode, out_ts,
                   mq[0].d, mq[0].m, mq[0].ts);
        end
      end
      checks++;
      if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL rnd_ovf cyc %0d got %b/%0d exp %b/%0d", k, overflow, drop_cnt, m_ovf, m_drop);
      end
    end
    trig = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture(1'b0);
    test_capture(1'b1);
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
